// File: rtl/bus_transfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bus_transfer_sequencer
// Description : Register bank plus a three-state sequencer that moves one
//               word src -> dst over the shared Sbus per accepted command.
//               Drives the registered Sbus value and one-hot SRx strobes to
//               the per-bit holding logic and feeds the register contents
//               back on reg_flat.
//               Optional macro TRANSFER_IMM_EN enables the immediate source.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_transfer_sequencer #(
    parameter int NREG  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [IDXW-1:0]       cmd_src,
    input  logic [IDXW-1:0]       cmd_dst,
    input  logic                  cmd_imm_sel,
    input  logic [WIDTH-1:0]      cmd_imm,
    output logic [WIDTH-1:0]      sbus,
    output logic [NREG-1:0]       sr,
    output logic                  done,
    output logic                  busy,
    output logic [NREG*WIDTH-1:0] reg_flat
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;

    logic [1:0]       r_state;
    logic             r_ready;
    logic             r_busy;
    logic [IDXW-1:0]  r_src;
    logic [IDXW-1:0]  r_dst;
    logic [WIDTH-1:0] r_sbus;
    logic [NREG-1:0]  r_sr;
    logic             r_commit;
    logic             r_done;
    logic [WIDTH-1:0] r_regs [NREG];

    logic             w_accept;
    logic [WIDTH-1:0] w_src_data;
    logic [WIDTH-1:0] w_read_data;
    logic [NREG-1:0]  w_dst_onehot;

    assign w_accept = cmd_valid & r_ready;

    // Source register lookup; an index with no matching register reads as 0
    always_comb begin
        w_src_data = '0;
        for (int i = 0; i < NREG; i++) begin
            if (r_src == IDXW'(i)) begin
                w_src_data = r_regs[i];
            end
        end
    end

    // Destination decode; an index with no matching register yields no strobe
    always_comb begin
        w_dst_onehot = '0;
        for (int i = 0; i < NREG; i++) begin
            if (r_dst == IDXW'(i)) begin
                w_dst_onehot[i] = 1'b1;
            end
        end
    end

`ifdef TRANSFER_IMM_EN
    logic             r_imm_sel;
    logic [WIDTH-1:0] r_imm;

    // Capture the immediate operands together with the rest of the command
    always_ff @(posedge clk) begin
        if (rst) begin
            r_imm_sel <= 1'b0;
            r_imm     <= '0;
        end else if (w_accept) begin
            r_imm_sel <= cmd_imm_sel;
            r_imm     <= cmd_imm;
        end
    end

    assign w_read_data = r_imm_sel ? r_imm : w_src_data;
`else
    // Immediate ports stay on the interface but carry no function here
    logic w_unused_imm;
    assign w_unused_imm = ^{cmd_imm_sel, cmd_imm};
    assign w_read_data  = w_src_data;
`endif

    // Sequencer: IDLE accepts, READ loads Sbus, WRITE issues the strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_src    <= '0;
            r_dst    <= '0;
            r_sbus   <= '0;
            r_sr     <= '0;
            r_commit <= 1'b0;
        end else begin
            r_sr     <= '0;
            r_commit <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_src   <= cmd_src;
                        r_dst   <= cmd_dst;
                        r_state <= c_READ;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                c_READ: begin
                    r_sbus  <= w_read_data;
                    r_state <= c_WRITE;
                end
                c_WRITE: begin
                    // Strobe and commit flag are registered, so they appear
                    // in the cycle after WRITE while Sbus is still stable
                    r_sr     <= w_dst_onehot;
                    r_commit <= 1'b1;
                    r_state  <= c_IDLE;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Holding equation: reg[i] takes Sbus when its strobe is up; done follows
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_done <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (r_sr[i]) begin
                    r_regs[i] <= r_sbus;
                end
            end
            r_done <= r_commit;
        end
    end

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_flat
            assign reg_flat[gi*WIDTH +: WIDTH] = r_regs[gi];
        end
    endgenerate

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign sbus      = r_sbus;
    assign sr        = r_sr;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bus_transfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_transfer_sequencer
// Description : Bench for bus_transfer_sequencer (NREG=3 so index 3 is out of
//               range). Transaction-level model of the transfer timing plus
//               directed literal expectations and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_transfer_sequencer;

    localparam int NREG  = 3;
    localparam int WIDTH = 8;
    localparam int IDXW  = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cmd_valid = 1'b0;
    logic                  cmd_ready;
    logic [IDXW-1:0]       cmd_src = '0;
    logic [IDXW-1:0]       cmd_dst = '0;
    logic                  cmd_imm_sel = 1'b0;
    logic [WIDTH-1:0]      cmd_imm = '0;
    logic [WIDTH-1:0]      sbus;
    logic [NREG-1:0]       sr;
    logic                  done;
    logic                  busy;
    logic [NREG*WIDTH-1:0] reg_flat;

    int checks   = 0;
    int failures = 0;

    bus_transfer_sequencer #(.NREG(NREG), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm_sel(cmd_imm_sel),
        .cmd_imm(cmd_imm), .sbus(sbus), .sr(sr), .done(done), .busy(busy),
        .reg_flat(reg_flat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A transfer accepted at edge a loads Sbus at a+1, strobes during a+2..a+3
    // and commits (register write + done) at edge a+3.
    typedef struct {
        int              a;
        logic [IDXW-1:0] src;
        logic [IDXW-1:0] dst;
        logic            isel;
        logic [WIDTH-1:0] imm;
        logic [WIDTH-1:0] val;
    } xfer_t;

    xfer_t            q[$];
    xfer_t            nx;
    logic [WIDTH-1:0] m_regs [NREG];
    logic [WIDTH-1:0] m_sbus  = '0;
    logic [NREG-1:0]  m_sr    = '0;
    logic             m_done  = 1'b0;
    logic             m_busy  = 1'b0;
    logic             m_ready = 1'b1;
    logic             m_valid = 1'b0;
    int               e = 0;

    function automatic logic [WIDTH-1:0] source_value(input xfer_t t);
`ifdef TRANSFER_IMM_EN
        if (t.isel) return t.imm;
`endif
        if (int'(t.src) < NREG) return m_regs[int'(t.src)];
        return '0;
    endfunction

    always @(posedge clk) begin
        e++;
        if (rst) begin
            q.delete();
            for (int i = 0; i < NREG; i++) m_regs[i] = '0;
            m_sbus = '0; m_sr = '0; m_done = 1'b0; m_busy = 1'b0;
            m_ready = 1'b1; m_valid = 1'b1;
        end else if (m_valid) begin
            m_done = 1'b0;
            m_sr   = '0;
            for (int i = 0; i < q.size(); i++) begin
                if (e == q[i].a + 1) begin
                    q[i].val = source_value(q[i]);
                    m_sbus   = q[i].val;
                end
                if (e == q[i].a + 2 && int'(q[i].dst) < NREG) m_sr[int'(q[i].dst)] = 1'b1;
                if (e == q[i].a + 3) begin
                    if (int'(q[i].dst) < NREG) m_regs[int'(q[i].dst)] = q[i].val;
                    m_done = 1'b1;
                end
            end
            if (cmd_valid && m_ready) begin
                nx.a = e; nx.src = cmd_src; nx.dst = cmd_dst;
                nx.isel = cmd_imm_sel; nx.imm = cmd_imm; nx.val = '0;
                q.push_back(nx);
            end
            while (q.size() > 0 && q[0].a + 3 <= e) void'(q.pop_front());
            m_busy = 1'b0;
            for (int i = 0; i < q.size(); i++) if (e < q[i].a + 2) m_busy = 1'b1;
            m_ready = !m_busy;
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic [NREG*WIDTH-1:0] exp_flat;
        if (m_valid) begin
            for (int i = 0; i < NREG; i++) exp_flat[i*WIDTH +: WIDTH] = m_regs[i];
            chk("sbus",      32'(sbus),      32'(m_sbus));
            chk("sr",        32'(sr),        32'(m_sr));
            chk("done",      32'(done),      32'(m_done));
            chk("busy",      32'(busy),      32'(m_busy));
            chk("cmd_ready", 32'(cmd_ready), 32'(m_ready));
            chk("reg_flat",  32'(reg_flat),  32'(exp_flat));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IDXW-1:0] s, input logic [IDXW-1:0] d,
                        input logic isel, input logic [WIDTH-1:0] imm);
        cmd_valid = 1'b1; cmd_src = s; cmd_dst = d; cmd_imm_sel = isel; cmd_imm = imm;
        step();
        cmd_valid = 1'b0;
        cmd_src = IDXW'($urandom); cmd_dst = IDXW'($urandom);
        cmd_imm_sel = 1'($urandom); cmd_imm = WIDTH'($urandom);
    endtask

    initial begin
        // reset for two edges, then idle
        step(); step();
        rst = 1'b0;
        step();
        chk("lit_reset_ready", 32'(cmd_ready), 32'd1);
        chk("lit_reset_flat",  32'(reg_flat),  32'd0);
        chk("lit_reset_sbus",  32'(sbus),      32'd0);
        chk("lit_reset_sr",    32'(sr),        32'd0);
        chk("lit_reset_done",  32'(done),      32'd0);

        // immediate A5 -> reg2
        send(2'd0, 2'd2, 1'b1, 8'hA5);
        chk("lit_imm_busy", 32'(busy), 32'd1);
        step();
`ifdef TRANSFER_IMM_EN
        chk("lit_imm_sbus", 32'(sbus), 32'hA5);
`else
        chk("lit_imm_sbus", 32'(sbus), 32'h00);
`endif
        chk("lit_imm_sr_early", 32'(sr), 32'd0);
        step();
        chk("lit_imm_sr", 32'(sr), 32'b100);
        step();
        chk("lit_imm_done", 32'(done), 32'd1);
        chk("lit_imm_sr_clear", 32'(sr), 32'd0);
`ifdef TRANSFER_IMM_EN
        chk("lit_imm_flat", 32'(reg_flat), 32'hA5_00_00);
`else
        chk("lit_imm_flat", 32'(reg_flat), 32'h00_00_00);
`endif

        // reg2 -> reg0 with cmd_valid held: second accept at N+3
        cmd_valid = 1'b1; cmd_src = 2'd2; cmd_dst = 2'd0; cmd_imm_sel = 1'b0;
        step(); step();
        step();
        chk("lit_xfer_sr", 32'(sr), 32'b001);
        step();
        chk("lit_xfer_done", 32'(done), 32'd1);
        chk("lit_xfer_reaccept", 32'(busy), 32'd1);
`ifdef TRANSFER_IMM_EN
        chk("lit_xfer_flat", 32'(reg_flat), 32'hA5_00_A5);
`else
        chk("lit_xfer_flat", 32'(reg_flat), 32'h00_00_00);
`endif
        cmd_valid = 1'b0;
        step(); step(); step();
        chk("lit_xfer2_done", 32'(done), 32'd1);

        // out-of-range destination: no strobe, done still pulses
        send(2'd2, 2'd3, 1'b0, 8'h00);
        step(); step();
        chk("lit_oor_dst_sr", 32'(sr), 32'd0);
        step();
        chk("lit_oor_dst_done", 32'(done), 32'd1);

        // out-of-range source reads as 0
        send(2'd3, 2'd1, 1'b0, 8'h00);
        step();
        chk("lit_oor_src_sbus", 32'(sbus), 32'd0);
        step(); step();
        chk("lit_oor_src_reg1", 32'(reg_flat[15:8]), 32'd0);

        // immediate selected with src=0: only honoured when the feature exists
        send(2'd0, 2'd1, 1'b1, 8'h3C);
        step(); step(); step();
`ifdef TRANSFER_IMM_EN
        chk("lit_imm_sel_reg1", 32'(reg_flat[15:8]), 32'h3C);
`else
        chk("lit_imm_sel_reg1", 32'(reg_flat[15:8]), 32'h00);
`endif

        // src == dst rewrites itself
        send(2'd1, 2'd1, 1'b0, 8'h00);
        step(); step(); step();
        chk("lit_self_done", 32'(done), 32'd1);
`ifdef TRANSFER_IMM_EN
        chk("lit_self_reg1", 32'(reg_flat[15:8]), 32'h3C);
`else
        chk("lit_self_reg1", 32'(reg_flat[15:8]), 32'h00);
`endif

        // reset during the strobe cycle aborts the commit
        send(2'd1, 2'd2, 1'b0, 8'h00);
        step(); step();
        rst = 1'b1;
        step();
        chk("lit_abort_done", 32'(done), 32'd0);
        chk("lit_abort_flat", 32'(reg_flat), 32'd0);
        rst = 1'b0;
        step();

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            cmd_valid   = ($urandom_range(0, 3) != 0);
            cmd_src     = IDXW'($urandom);
            cmd_dst     = IDXW'($urandom);
            cmd_imm_sel = 1'($urandom);
            cmd_imm     = WIDTH'($urandom);
            rst         = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
